instr_trace_buffer: RTL and testbench

- Synthesizable retired-instruction trace capture for the ARM-subset cpu. Replaces simulation-only $display tracing with an on-chip, parametrised circular buffer.
- Records {cond_pass, pc, inst} per valid trace beat. Arms, waits for a selectable trigger, captures a programmable post-trigger window, then freezes for readout through a pop port.
- Sits beside cpu, fed from the execute-stage trace tap. Readout drives the debug ports.

---
 rtl/instr_trace_buffer_if.sv | 28 ++
 rtl/instr_trace_buffer.sv | 74 +++++++
 tb/tb_instr_trace_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_trace_buffer_if.sv
// instr_trace_buffer_if: trace tap, trigger control and readout bundle for instr_trace_buffer.
interface instr_trace_buffer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int INST_WIDTH = 32,
   parameter int DEPTH_LOG2 = 4
);
   logic                              trace_valid;
   logic [ADDR_WIDTH-1:0]             trace_pc;
   logic [INST_WIDTH-1:0]             trace_inst;
   logic                              trace_cond_pass;
   logic                              arm;
   logic [1:0]                        trig_mode;
   logic [ADDR_WIDTH-1:0]             trig_pc;
   logic                              rd_en;
   logic [ADDR_WIDTH+INST_WIDTH:0]    rd_data;
   logic                              rd_valid;
   logic [DEPTH_LOG2:0]               count;
   logic [1:0]                        state;
   logic                              done;
   modport master (
      output trace_valid, trace_pc, trace_inst, trace_cond_pass, arm, trig_mode, trig_pc, rd_en,
      input  rd_data, rd_valid, count, state, done
   );
   modport slave (
      input  trace_valid, trace_pc, trace_inst, trace_cond_pass, arm, trig_mode, trig_pc, rd_en,
      output rd_data, rd_valid, count, state, done
   );
endinterface

// File: rtl/instr_trace_buffer.sv
// instr_trace_buffer: circular retired-instruction trace buffer with trigger,
// post-trigger window and oldest-first pop readout once frozen.
module instr_trace_buffer #(
   parameter int ADDR_WIDTH   = 32,
   parameter int INST_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 4,
   parameter int POST_TRIGGER = 8
) (
   input  logic              clk,
   input  logic              reset,
   instr_trace_buffer_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DW    = 1 + ADDR_WIDTH + INST_WIDTH;
   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;
   typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
   state_t          state_q;
   ptr_t            wr_ptr_q, rd_ptr_q, post_q;
   cnt_t            count_q;
   logic            rd_valid_q;
   logic [DW-1:0]   rd_data_q;
   logic [DW-1:0]   mem_q [DEPTH];
   logic            hit, cap, full, pop;
   always_comb begin
      hit  = bus.trig_mode == 2'd0 ? 1'b1 :
             bus.trig_mode == 2'd1 ? bus.trace_pc == bus.trig_pc :
             bus.trig_mode == 2'd2 ? bus.trace_inst[27:25] == 3'b101 :
                                     !bus.trace_cond_pass;
      cap  = bus.trace_valid && !bus.arm && (state_q == PRE || state_q == POST);
      full = count_q == cnt_t'(DEPTH);
      pop  = state_q == DONE && bus.rd_en && count_q != '0 && !bus.arm;
   end
   always_ff @(posedge clk)
      if (cap) mem_q[wr_ptr_q] <= {bus.trace_cond_pass, bus.trace_pc, bus.trace_inst};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_q     <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else if (bus.arm) begin
         state_q    <= PRE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_q     <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= pop;
         if (pop) rd_data_q <= mem_q[rd_ptr_q];
         if (cap) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
         // a full buffer drops its oldest entry so the read pointer follows the write
         if (pop || (cap && full)) rd_ptr_q <= rd_ptr_q + ptr_t'(1);
         if (pop) count_q <= count_q - cnt_t'(1);
         else if (cap && !full) count_q <= count_q + cnt_t'(1);
         if (cap && state_q == PRE && hit) begin
            post_q  <= ptr_t'(POST_TRIGGER);
            state_q <= POST_TRIGGER == 0 ? DONE : POST;
         end else if (cap && state_q == POST) begin
            post_q  <= post_q - ptr_t'(1);
            if (post_q == ptr_t'(1)) state_q <= DONE;
         end
      end
   end
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.count    = count_q;
   assign bus.state    = state_q;
   assign bus.done     = state_q == DONE;
endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb_instr_trace_buffer: two buffers (post window 8 and 0) fed identical stimulus,
// each compared every cycle against a queue-based reference model.
module tb_instr_trace_buffer;
   localparam int AW = 32, IW = 32, DL = 4, DEPTH = 16, DW = 65;
   logic clk = 1'b0, reset;
   always #5 clk = ~clk;
   logic tv, cp, arm, rd_en;
   logic [AW-1:0] pc, tpc;
   logic [IW-1:0] inst;
   logic [1:0] mode;
   instr_trace_buffer_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH_LOG2(DL)) b0(), b1();
   assign {b0.trace_valid, b0.trace_pc, b0.trace_inst, b0.trace_cond_pass} = {tv, pc, inst, cp};
   assign {b1.trace_valid, b1.trace_pc, b1.trace_inst, b1.trace_cond_pass} = {tv, pc, inst, cp};
   assign {b0.arm, b0.trig_mode, b0.trig_pc, b0.rd_en} = {arm, mode, tpc, rd_en};
   assign {b1.arm, b1.trig_mode, b1.trig_pc, b1.rd_en} = {arm, mode, tpc, rd_en};
   instr_trace_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH_LOG2(DL), .POST_TRIGGER(8))
      u0 (.clk(clk), .reset(reset), .bus(b0));
   instr_trace_buffer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH_LOG2(DL), .POST_TRIGGER(0))
      u1 (.clk(clk), .reset(reset), .bus(b1));
   logic [1:0]    o_st  [2];
   logic [DL:0]   o_cnt [2];
   logic          o_rv  [2];
   logic          o_dn  [2];
   logic [DW-1:0] o_rd  [2];
   assign {o_st[0], o_cnt[0], o_rv[0], o_dn[0], o_rd[0]} = {b0.state, b0.count, b0.rd_valid, b0.done, b0.rd_data};
   assign {o_st[1], o_cnt[1], o_rv[1], o_dn[1], o_rd[1]} = {b1.state, b1.count, b1.rd_valid, b1.done, b1.rd_data};
   int            st [2], post [2];
   int            pt [2] = '{8, 0};
   logic          rv [2];
   logic [DW-1:0] rdat [2];
   logic [DW-1:0] mq [2][$];
   int checks = 0, errors = 0;
   task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic hit();
      case (mode)
         2'd0: return 1'b1;
         2'd1: return pc == tpc;
         2'd2: return inst[27:25] == 3'b101;
         default: return !cp;
      endcase
   endfunction
   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         st[k] = 0; post[k] = 0; rv[k] = 1'b0; rdat[k] = '0;
         mq[k].delete();
      end
   endtask
   task automatic model();
      for (int k = 0; k < 2; k++) begin
         rv[k] = 1'b0;
         if (arm) begin
            mq[k].delete(); st[k] = 1; post[k] = 0;
         end else if (st[k] == 3) begin
            if (rd_en && mq[k].size() > 0) begin
               rv[k] = 1'b1; rdat[k] = mq[k].pop_front();
            end
         end else if ((st[k] == 1 || st[k] == 2) && tv) begin
            mq[k].push_back({cp, pc, inst});
            if (mq[k].size() > DEPTH) void'(mq[k].pop_front());
            if (st[k] == 1) begin
               if (hit()) begin
                  post[k] = pt[k];
                  st[k] = pt[k] == 0 ? 3 : 2;
               end
            end else begin
               post[k]--;
               if (post[k] == 0) st[k] = 3;
            end
         end
      end
   endtask
   task automatic compare();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("state%0d", k), o_st[k], st[k]);
         check($sformatf("count%0d", k), o_cnt[k], mq[k].size());
         check($sformatf("rd_valid%0d", k), o_rv[k], rv[k]);
         check($sformatf("done%0d", k), o_dn[k], st[k] == 3);
         if (rv[k]) check($sformatf("rd_data%0d", k), o_rd[k], rdat[k]);
      end
   endtask
   task automatic step();
      model();
      @(posedge clk);
      #1;
      compare();
   endtask
   task automatic beat(input logic v, input logic [AW-1:0] p, input logic [IW-1:0] i, input logic c);
      tv = v; pc = p; inst = i; cp = c;
      step();
      tv = 1'b0;
   endtask
   task automatic do_arm();
      arm = 1'b1;
      step();
      arm = 1'b0;
   endtask
   task automatic pops(input int n);
      rd_en = 1'b1;
      repeat (n) step();
      rd_en = 1'b0;
      step();
   endtask
   task automatic async_reset();
      #2 reset = 1'b1;
      #1 mreset();
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_state%0d", k), o_st[k], 0);
         check($sformatf("rst_count%0d", k), o_cnt[k], 0);
         check($sformatf("rst_rv%0d", k), o_rv[k], 0);
      end
      @(posedge clk);
      #1 reset = 1'b0;
   endtask
   initial begin
      {tv, cp, arm, rd_en, mode} = '0;
      pc = '0; tpc = '0; inst = '0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 mreset();
      compare();
      check("rst_rd_data", o_rd[0], 0);
      reset = 1'b0;
      step();
      // mode 0: nine sequential beats fill the window
      mode = 2'd0;
      do_arm();
      for (int i = 0; i < 9; i++) beat(1'b1, AW'(i * 4), $urandom, 1'b1);
      check("mode0_count", o_cnt[0], 9);
      check("mode0_done", o_dn[0], 1);
      pops(10);
      // mode 1: trigger on pc 0x40 after the buffer has wrapped
      mode = 2'd1; tpc = 32'h40;
      do_arm();
      for (int i = 0; i < 30; i++) beat(1'b1, AW'(i * 4), $urandom, 1'b1);
      check("mode1_count", o_cnt[0], 16);
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
         step();
         check("mode1_pop_pc", o_rd[0][63:32], 32'h24 + 32'(i * 4));
      end
      rd_en = 1'b0;
      step();
      // mode 2: branch class
      mode = 2'd2;
      do_arm();
      for (int i = 0; i < 4; i++) beat(1'b1, AW'(i * 4), 32'hE0810002, 1'b1);
      beat(1'b1, 32'h10, 32'hEA000003, 1'b1);
      check("mode2_done1", o_dn[1], 1);
      for (int i = 0; i < 10; i++) beat(1'b1, AW'(32'h14 + i * 4), 32'hE0810002, 1'b1);
      pops(17);
      check("mode2_last_inst", o_rd[1][31:0], 32'hEA000003);
      // mode 3: condition fail, with idle beats that must not count
      mode = 2'd3;
      do_arm();
      beat(1'b1, 32'h0, 32'hE0810002, 1'b1);
      beat(1'b1, 32'h4, 32'h0A000001, 1'b0);
      for (int i = 0; i < 12; i++) beat(i[0], AW'(32'h8 + i * 4), 32'hE0810002, 1'b1);
      pops(3);
      // arm while DONE with entries left; the beat in the arm cycle is dropped
      mode = 2'd0;
      do_arm();
      for (int i = 0; i < 4; i++) beat(1'b1, AW'(i * 4), $urandom, 1'b1);
      tv = 1'b1; pc = 32'h100; arm = 1'b1;
      step();
      arm = 1'b0; tv = 1'b0;
      check("rearm_count", o_cnt[0], 0);
      check("rearm_state", o_st[0], 1);
      // reset in the middle of the post window
      do_arm();
      for (int i = 0; i < 5; i++) beat(1'b1, AW'(i * 4), $urandom, 1'b1);
      async_reset();
      pops(2);
      // random campaigns
      for (int r = 0; r < 40; r++) begin
         mode = 2'($urandom_range(0, 3));
         tpc = AW'($urandom_range(0, 15) * 4);
         do_arm();
         for (int c = 0; c < 40; c++) begin
            logic [IW-1:0] w;
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[27:25] = 3'b101;
            if ($urandom_range(0, 60) == 0) begin
               arm = 1'b1;
               step();
               arm = 1'b0;
            end else beat($urandom_range(0, 9) < 7, AW'($urandom_range(0, 15) * 4), w, $urandom_range(0, 4) != 0);
         end
         for (int c = 0; c < 24; c++) begin
            rd_en = 1'($urandom);
            tv = 1'($urandom);
            step();
         end
         rd_en = 1'b0; tv = 1'b0;
         if ($urandom_range(0, 9) == 0) async_reset();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
